// File: rtl/alu_pipe.sv
// alu_pipe: handshaked execute-stage ALU with parametrised width.
// Single-cycle ops take one EXEC cycle. MUL runs an iterative shift-add
// multiplier for WIDTH cycles. Results sit in an output register with
// valid/ready backpressure.
module alu_pipe #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zero,
  output logic             carry,
  output logic             err
);

  // Reject widths the shift-amount derivation and multiplier counter cannot support.
  if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("alu_pipe: WIDTH must be a power of two between 8 and 64");
  end

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_NOT = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL,
    MDONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;      // operand A; doubles as the shifting multiplicand
  logic [WIDTH-1:0] b_q;      // operand B; doubles as the shifting multiplier
  logic [WIDTH-1:0] acc_q;    // multiplier partial product
  logic [SHW-1:0]   cnt_q;    // multiplier step counter, 0..WIDTH-1

  logic             in_xfer;
  logic             out_free;
  logic             wr_res;
  logic             new_is_mul;

  logic [WIDTH-1:0] res_f;
  logic             res_carry;
  logic             res_err;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;

  // Handshake qualifiers. The output register is free when empty or draining this cycle.
  assign out_free   = !out_valid || out_ready;
  assign in_ready   = (state_q == IDLE) ||
                      ((state_q == EXEC || state_q == MDONE) && out_free);
  assign in_xfer    = in_valid && in_ready;
  assign wr_res     = (state_q == EXEC || state_q == MDONE) && out_free;
  assign new_is_mul = (aluop == OP_MUL);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, whatever the block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: EXEC/MDONE leave only once their result is written,
  // and may chain straight into a newly accepted op.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // state_d unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_xfer) state_d = new_is_mul ? MUL : EXEC;
      end
      EXEC, MDONE: begin
        if (out_free) begin
          if (in_xfer) state_d = new_is_mul ? MUL : EXEC;
          else         state_d = IDLE;
        end
      end
      MUL: begin
        if (cnt_q == CNT_LAST) state_d = MDONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on accept, and one shift-add multiplier step per MUL cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (in_xfer) begin
      op_q  <= aluop;
      a_q   <= a;
      b_q   <= b;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == MUL) begin
      acc_q <= acc_q + (b_q[0] ? a_q : '0);
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign sum   = {1'b0, a_q} + {1'b0, b_q};
  assign shamt = b_q[SHW-1:0];

  // Result mux: captured operands in EXEC, finished product in MDONE.
  always_comb begin
    res_f     = '0;
    res_carry = 1'b0;
    res_err   = 1'b0;
    if (state_q == MDONE) begin
      res_f = acc_q;
    end else begin
      case (op_q)
        OP_AND: res_f = a_q & b_q;
        OP_OR:  res_f = a_q | b_q;
        OP_NOT: res_f = ~a_q;
        OP_ADD: begin
          res_f     = sum[WIDTH-1:0];
          res_carry = sum[WIDTH];
        end
        OP_SUB: begin
          res_f     = a_q - b_q;
          res_carry = (a_q < b_q);
        end
        OP_SHL: res_f = a_q << shamt;
        OP_SHR: res_f = a_q >> shamt;
        OP_SRA: res_f = $unsigned($signed(a_q) >>> shamt);
        default: begin
          // Opcode 8 never reaches EXEC, so everything here is illegal.
          res_f   = '0;
          res_err = 1'b1;
        end
      endcase
    end
  end

  // Output register: a newly written result wins over a same-cycle drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      f         <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      err       <= 1'b0;
    end else if (wr_res) begin
      out_valid <= 1'b1;
      f         <= res_f;
      zero      <= (res_f == '0);
      carry     <= res_carry;
      err       <= res_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32): table vectors, MUL latency,
// backpressure ordering, random traffic and asynchronous reset mid-MUL.
module tb_alu_pipe;

  localparam int W   = 32;
  localparam int SHW = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   aluop;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic         zero;
  logic         carry;
  logic         err;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .zero      (zero),
    .carry     (carry),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] f;
    logic         z;
    logic         c;
    logic         e;
    int           acc;   // cycle count after the accept edge
    int           lat;   // required accept-to-result edges, 0 = unchecked
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] f;
    logic         z;
    logic         c;
    logic         e;
  } vec_t;

  exp_t sb[$];
  exp_t pend;
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  int   pop_cyc = 0;
  logic last_in = 1'b0;
  logic rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(logic [W-1:0] rf, logic rz, logic rc, logic re, int lat);
    exp_t e;
    e.f = rf; e.z = rz; e.c = rc; e.e = re; e.acc = 0; e.lat = lat;
    return e;
  endfunction

  // Reference behaviour written from the opcode table.
  function automatic exp_t model(logic [3:0] op, logic [W-1:0] x, logic [W-1:0] y);
    exp_t       e;
    logic [W:0] s;
    e = mk('0, 1'b0, 1'b0, 1'b0, 0);
    case (op)
      4'd0: e.f = x & y;
      4'd1: e.f = x | y;
      4'd2: e.f = ~x;
      4'd3: begin s = {1'b0, x} + {1'b0, y}; e.f = s[W-1:0]; e.c = s[W]; end
      4'd4: begin e.f = x - y; e.c = (x < y); end
      4'd5: e.f = x << y[SHW-1:0];
      4'd6: e.f = x >> y[SHW-1:0];
      4'd7: e.f = $unsigned($signed(x) >>> y[SHW-1:0]);
      4'd8: e.f = x * y;
      default: e.e = 1'b1;
    endcase
    e.z = (e.f == '0);
    return e;
  endfunction

  // One clock: sample pre-edge handshakes, advance, then update scoreboard.
  task automatic tick();
    logic         xo, xi, sz, sc, se;
    logic [W-1:0] sf;
    int           cpre;
    exp_t         e;
    #1;
    xo = out_valid && out_ready;
    xi = in_valid && in_ready;
    sf = f; sz = zero; sc = carry; se = err;
    cpre = cyc;
    @(posedge clk);
    #1;
    cyc++;
    last_in = xi;
    if (xi) begin
      e = pend;
      e.acc = cyc;
      sb.push_back(e);
    end
    if (xo) begin
      pop_cyc = cyc;
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL spurious_out: got f=0x%0h with no pending op, expected none", sf);
      end else begin
        e = sb.pop_front();
        check("result{f,z,c,e}", 64'({sf, sz, sc, se}), 64'({e.f, e.z, e.c, e.e}));
        if (e.lat != 0) check("latency", 64'(cpre - e.acc + 1), 64'(e.lat));
      end
    end
    if (rand_ready) out_ready = 1'($urandom);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input exp_t e);
    pend = e;
    aluop = op; a = x; b = y; in_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (last_in) break;
    end
    if (!last_in) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: got no accept for op %0d, expected accept", op);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (sb.size() == 0 && !out_valid) break;
      tick();
    end
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  vec_t tbl[14];
  exp_t ex;
  int   p1;

  initial begin
    tbl[0]  = '{4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{4'd4, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{4'd7, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{4'd6, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{4'd5, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{4'd0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{4'd1, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{4'd2, 32'h0F0F_0F0F, 32'h1234_5678, 32'hF0F0_F0F0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{4'd12, 32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{4'd3, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{4'd4, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{4'd4, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{4'd5, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{4'd7, 32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; aluop = '0; a = '0; b = '0; out_ready = 1'b1;
    pend = mk('0, 1'b0, 1'b0, 1'b0, 0);

    // Reset state, then release away from the clock edge.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_outputs", 64'({f, zero, carry, err}), 64'(0));
    #2 rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Back-to-back table vectors with no backpressure; in_ready must stay high.
    foreach (tbl[i]) begin
      check("in_ready_b2b", 64'(in_ready), 64'(1));
      issue(tbl[i].op, tbl[i].a, tbl[i].b, mk(tbl[i].f, tbl[i].z, tbl[i].c, tbl[i].e, 2));
    end
    drain();

    // MUL latency, with in_ready low for every multiplier step and
    // churning inputs that must be ignored.
    issue(4'd8, 32'h0001_0001, 32'h0001_0001, mk(32'h0002_0001, 1'b0, 1'b0, 1'b0, W + 2));
    for (int i = 0; i < W; i++) begin
      check("in_ready_mul", 64'(in_ready), 64'(0));
      in_valid = 1'($urandom); aluop = 4'($urandom); a = $urandom; b = $urandom;
      pend = model(aluop, a, b);
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: AND result holds while OR stalls, then both drain in order.
    out_ready = 1'b0;
    ex = model(4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF);
    issue(4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, ex);
    issue(4'd1, 32'hF0F0_1234, 32'h0FF0_FFFF, model(4'd1, 32'hF0F0_1234, 32'h0FF0_FFFF));
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", 64'(out_valid), 64'(1));
      check("stall_hold_f", 64'(f), 64'(ex.f));
      check("stall_in_ready", 64'(in_ready), 64'(0));
      tick();
    end
    out_ready = 1'b1;
    tick();
    p1 = pop_cyc;
    tick();
    check("or_next_cycle", 64'(pop_cyc - p1), 64'(1));
    check("no_duplicate", 64'(out_valid), 64'(0));
    drain();

    // Random traffic with random consumer backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [3:0]   op;
      logic [W-1:0] x, y;
      op = 4'($urandom_range(0, 15)); x = $urandom; y = $urandom;
      if (i % 5 == 0) y = y & 32'h0000_00FF;
      issue(op, x, y, model(op, x, y));
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    // Asynchronous reset at MUL step 10 discards the operation.
    issue(4'd8, 32'h0000_0003, 32'h0000_0005, model(4'd8, 32'h3, 32'h5));
    for (int i = 0; i < 10; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'(0));
    check("async_rst_outputs", 64'({f, zero, carry, err}), 64'(0));
    check("async_rst_in_ready", 64'(in_ready), 64'(1));
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 2 * W; i++) begin
      check("post_rst_no_out", 64'(out_valid), 64'(0));
      check("post_rst_in_ready", 64'(in_ready), 64'(1));
      tick();
    end
    issue(4'd3, 32'h0000_0010, 32'h0000_0020, mk(32'h0000_0030, 1'b0, 1'b0, 1'b0, 2));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
